apb_master_gen: RTL and testbench
=================================

# apb_master_gen

Parametrised APB4 master bridging the internal single-request interface (transfer/ready) to up to NUM_SLV APB peripherals on a fixed-stride address map. It is the next generation of the six-slave APB master. Over that block it adds slave count, address and data width parameters, PSTRB and PSLVERR support, a decode-error response for unmapped addresses, a PREADY timeout and a registered completion pulse. It sits between the CPU-side bus logic and the peripheral slaves (GPIO, FND, UART, ...).

## Interface
- NUM_SLV, 6: number of APB slaves (1..16)
- ADDR_W, 32: address width
- DATA_W, 32: data width (multiple of 8)
- BASE_ADDR, 32'h1000_0000: address of slave 0
- SPAN_BITS, 12: log2 of the per-slave window (4 KiB)
- TIMEOUT, 16: maximum ACCESS cycles before abort; 0 disables the timeout
- PCLK  in  1  clock; single clock domain
- PRESET  in  1  reset; synchronous, active-high
- PADDR  out  ADDR_W  latched address
- PWRITE  out  1  latched direction
- PENABLE  out  1  high in ACCESS only
- PWDATA  out  DATA_W  latched write data
- PSTRB  out  DATA_W/8  latched byte strobes; forced to 0 for reads
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA  in  NUM_SLV*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-slave ready
- PSLVERR  in  NUM_SLV  per-slave error
- transfer  in  1  request strobe; sampled only when busy=0
- write  in  1  1=write, 0=read
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  request write data
- strb  in  DATA_W/8  request byte strobes
- busy  out  1  high whenever state is not IDLE
- ready  out  1  one-cycle completion pulse (registered)
- rdata  out  DATA_W  read result; held until the next completion
- err  out  1  error flag; valid only with ready

## Operation
- States: IDLE, SETUP, ACCESS, DERR.
- IDLE, transfer=1:
  - latch addr, write, wdata and strb into registers (strb latched as 0 when write=0).
  - decode: idx = (addr - BASE_ADDR) >> SPAN_BITS; the address is mapped iff addr >= BASE_ADDR and idx < NUM_SLV.
  - mapped: latch idx and go to SETUP. Unmapped: go to DERR.
- SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. The timeout counter increments each cycle with PREADY[idx]=0.
  - PREADY[idx]=1: return to IDLE. Next cycle: ready=1, err=PSLVERR[idx].
    - Read: rdata=PRDATA[idx]. Write: rdata unchanged.
  - Timeout: TIMEOUT≠0 and the TIMEOUT-th ACCESS cycle ends with PREADY low. Abort to IDLE. Next cycle: ready=1, err=1, rdata=0 (on reads).
- DERR: no PSEL, no PENABLE. Return to IDLE. Next cycle: ready=1, err=1, rdata=0 on reads, unchanged on writes.
- PSEL and PENABLE are 0 in IDLE and DERR. PADDR, PWRITE, PWDATA and PSTRB always drive the latch registers and are stable from SETUP through ACCESS.
- Only PSEL[idx] can ever be high; at most one bit of PSEL is set.
- Inputs transfer, addr, write, wdata and strb are ignored while busy=1.

## Timing
- Reset, applied on a PCLK edge with PRESET=1: state=IDLE. The following are all 0 on the next edge, including when reset arrives mid-transfer:
  - PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL
  - busy, ready, rdata, err, the timeout counter
- Zero-wait transfer:
  - cycle 0 IDLE (transfer sampled)
  - cycle 1 SETUP
  - cycle 2 ACCESS (PREADY=1)
  - cycle 3 ready pulse and busy=0; a new transfer can be sampled in this same cycle
- Throughput: 3 cycles per transfer plus wait states.
- Decode error: transfer in cycle 0, DERR in cycle 1, ready in cycle 2.
- Timeout abort: ready arrives 2+TIMEOUT cycles after the request cycle.
- If PREADY and the timeout coincide in the same cycle, PREADY wins and the transfer completes normally.
- ready is high for exactly one cycle per accepted request. rdata and err update only on that cycle's edge.

## Test plan
- Reset behaviour: pulse PRESET during an ACCESS wait state -> next cycle PSEL=0, PENABLE=0, busy=0, ready=0, and a fresh transfer then completes normally.
- Zero-wait write: addr=32'h1000_2004, wdata=32'hDEAD_BEEF, strb=4'hF, PREADY[2]=1 -> PSEL=6'b000100. SETUP in cycle 1, ACCESS in cycle 2, ready in cycle 3 with err=0. PWDATA stays stable across SETUP and ACCESS.
- Wait-state read with error: addr=32'h1000_5000, slave 5 holds PREADY low for 3 cycles, then PRDATA5=32'h0000_00A5 and PSLVERR5=1 -> ready in cycle 6 with rdata=32'hA5, err=1, PSTRB=0 throughout.
- Decode error: addr=32'h1000_6000 (NUM_SLV=6), then separately addr=32'h0FFF_FFFC -> no PSEL ever asserted, ready in cycle 2 with err=1 and rdata=0.
- Timeout: TIMEOUT=4, slave 1 never asserts PREADY -> exactly 4 ACCESS cycles, then ready in cycle 6 with err=1. Repeat with PREADY asserted on the 4th ACCESS cycle -> normal completion, err=0.
- Back-to-back and parameter sweep: issue transfer in the cycle after each ready pulse -> one ready per request with no dropped requests. Ignore transfer pulses while busy=1. Rerun with NUM_SLV=2, DATA_W=16, SPAN_BITS=8 and check decode at 32'h1000_0100 -> PSEL=2'b10.

Source files
------------

// File: rtl/apb_master_gen.sv
// apb_master_gen: parametrised APB4 master that bridges a single-request
// transfer/ready port onto NUM_SLV peripherals laid out on a fixed-stride address map.
module apb_master_gen #(
    parameter int                NUM_SLV   = 6,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1000_0000),
    parameter int                SPAN_BITS = 12,
    parameter int                TIMEOUT   = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       strb,
    output logic                      busy,
    output logic                      ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err
);

    // Request side: a request is accepted on any edge where transfer=1 and busy=0;
    // every accepted request gets exactly one single-cycle ready pulse, with err/rdata valid alongside it.

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DERR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] req_off;
    logic [ADDR_W-1:0] req_win;
    logic              req_mapped;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              tmo_hit;

    always_comb begin
        req_off    = addr - BASE_ADDR;
        req_win    = req_off >> SPAN_BITS;
        req_mapped = (addr >= BASE_ADDR) && (req_win < ADDR_W'(NUM_SLV));
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // PREADY on the last allowed cycle takes priority over the abort.
    assign tmo_hit = (TIMEOUT != 0) && !sel_ready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (transfer) state_d = req_mapped ? S_SETUP : S_DERR;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (sel_ready || tmo_hit) state_d = S_IDLE;
            S_DERR:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        PENABLE = (state_q == S_ACCESS);
        PSEL    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            PSEL[i] = ((state_q == S_SETUP) || (state_q == S_ACCESS)) && (idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            idx_q    <= '0;
            tmo_cnt  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            tmo_cnt <= (state_q == S_ACCESS && !sel_ready) ? tmo_cnt + 1'b1 : '0;
            unique case (state_q)
                S_IDLE: begin
                    if (transfer) begin
                        paddr_q  <= addr;
                        pwrite_q <= write;
                        pwdata_q <= wdata;
                        pstrb_q  <= write ? strb : '0;
                        if (req_mapped) idx_q <= req_win[IDX_W-1:0];
                    end
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        ready_q <= 1'b1;
                        err_q   <= sel_err;
                        if (!pwrite_q) rdata_q <= sel_rdata;
                    end else if (tmo_hit) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        if (!pwrite_q) rdata_q <= '0;
                    end
                end
                S_DERR: begin
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                    if (!pwrite_q) rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    assign PSTRB  = pstrb_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_apb_master_gen.sv
// tb_apb_master_gen: drives apb_master_gen with directed and random APB traffic
// and compares completions against a transaction-level model of the address map.
module tb_apb_master_gen;

    localparam int          NS   = 6;
    localparam int          DW   = 32;
    localparam int          TMO  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [31:0]     PADDR;
    logic            PWRITE, PENABLE;
    logic [31:0]     PWDATA;
    logic [3:0]      PSTRB;
    logic [NS-1:0]   PSEL;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]   PREADY, PSLVERR;
    logic            transfer, write;
    logic [31:0]     addr, wdata;
    logic [3:0]      strb;
    logic            busy, ready, err;
    logic [31:0]     rdata;

    logic [31:0] d2_paddr;
    logic        d2_pwrite, d2_penable;
    logic [15:0] d2_pwdata;
    logic [1:0]  d2_pstrb, d2_psel, d2_pready, d2_pslverr;
    logic [31:0] d2_prdata;
    logic        d2_transfer, d2_write;
    logic [31:0] d2_addr;
    logic [15:0] d2_wdata;
    logic [1:0]  d2_strb;
    logic        d2_busy, d2_ready, d2_err;
    logic [15:0] d2_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_rdata = '0;
    logic [31:0] exp_q[$];

    always #5 PCLK = ~PCLK;

    apb_master_gen #(.NUM_SLV(NS), .DATA_W(DW), .TIMEOUT(TMO)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .strb(strb), .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    apb_master_gen #(.NUM_SLV(2), .DATA_W(16), .SPAN_BITS(8), .TIMEOUT(TMO)) u_dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(d2_paddr), .PWRITE(d2_pwrite), .PENABLE(d2_penable),
        .PWDATA(d2_pwdata), .PSTRB(d2_pstrb), .PSEL(d2_psel), .PRDATA(d2_prdata), .PREADY(d2_pready),
        .PSLVERR(d2_pslverr), .transfer(d2_transfer), .write(d2_write), .addr(d2_addr), .wdata(d2_wdata),
        .strb(d2_strb), .busy(d2_busy), .ready(d2_ready), .rdata(d2_rdata), .err(d2_err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transaction-level expectation straight from the address map and timing rules.
    function automatic void model(input logic wr, input logic [31:0] a, input int waits,
                                  input logic [31:0] rd, input logic se,
                                  output int lat, output logic [31:0] rdat, output logic e,
                                  output logic [NS-1:0] psel, output int acc);
        logic [31:0] win;
        win  = (a - BASE) >> 12;
        rdat = model_rdata;
        if (a < BASE || win >= 32'(NS)) begin
            lat = 2; e = 1'b1; psel = '0; acc = 0;
            if (!wr) rdat = '0;
        end else begin
            psel = NS'(1) << win;
            if (waits < 0 || waits >= TMO) begin
                lat = 2 + TMO; e = 1'b1; acc = TMO;
                if (!wr) rdat = '0;
            end else begin
                lat = 3 + waits; e = se; acc = waits + 1;
                if (!wr) rdat = rd;
            end
        end
        model_rdata = rdat;
    endfunction

    // Issues one request and acts as the addressed slave; waits<0 means never ready.
    task automatic run_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] sb, input int waits, input logic [31:0] rd,
                            input logic se, input logic noise,
                            output int lat, output logic [31:0] got_rdata, output logic got_err,
                            output logic [NS-1:0] psel_seen, output int acc_n, output logic bus_ok);
        logic [3:0] exp_strb;
        exp_strb  = wr ? sb : 4'h0;
        lat       = -1;
        got_rdata = '0;
        got_err   = 1'b0;
        psel_seen = '0;
        acc_n     = 0;
        bus_ok    = 1'b1;
        transfer  = 1'b1; write = wr; addr = a; wdata = wd; strb = sb;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            PREADY   = '0;
            PSLVERR  = NS'($urandom);
            for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
            if (ready) begin
                lat = c; got_rdata = rdata; got_err = err;
                if (busy) bus_ok = 1'b0;
                break;
            end
            if (PSEL != '0) begin
                psel_seen |= PSEL;
                if ($countones(PSEL) != 1 || PADDR !== a || PWRITE !== wr ||
                    PWDATA !== wd || PSTRB !== exp_strb) bus_ok = 1'b0;
                if (PENABLE) begin
                    acc_n++;
                    if (waits >= 0 && acc_n > waits) begin
                        for (int i = 0; i < NS; i++) begin
                            if (PSEL[i]) begin
                                PREADY[i] = 1'b1;
                                PRDATA[i*DW +: DW] = rd;
                                PSLVERR[i] = se;
                            end
                        end
                    end
                end
            end else if (PENABLE) begin
                bus_ok = 1'b0;
            end
            if (noise && busy) begin
                transfer = 1'($urandom_range(0, 1));
                write = 1'($urandom_range(0, 1));
                addr = $urandom; wdata = $urandom; strb = 4'($urandom);
            end
        end
        transfer = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        n_checks++; if ({PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL} !== '0)
            $display("FAIL reset_bus: got %h expected 0", {PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL}); else n_pass++;
        n_checks++; if ({busy, ready, rdata, err} !== '0)
            $display("FAIL reset_req: got %h expected 0", {busy, ready, rdata, err}); else n_pass++;
        PRESET = 1'b0;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010; wdata = $urandom; strb = 4'hF;
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (2) @(negedge PCLK);
        n_checks++; if ({PSEL, PENABLE} !== {6'b001000, 1'b1})
            $display("FAIL reset_pre_access: got %b expected %b", {PSEL, PENABLE}, {6'b001000, 1'b1}); else n_pass++;
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        n_checks++; if ({PSEL, PENABLE, busy, ready, err} !== '0)
            $display("FAIL reset_mid_xfer: got %b expected 0", {PSEL, PENABLE, busy, ready, err}); else n_pass++;
        n_checks++; if (PADDR !== 32'h0)
            $display("FAIL reset_mid_paddr: got %h expected 0", PADDR); else n_pass++;
        model_rdata = '0;
        begin
            int lat, acc, e_lat, e_acc;
            logic [31:0] got_rd, e_rd, rd;
            logic got_e, ok, e_e;
            logic [NS-1:0] ps, e_ps;
            rd = $urandom;
            model(1'b0, 32'h1000_0008, 0, rd, 1'b0, e_lat, e_rd, e_e, e_ps, e_acc);
            run_xfer(1'b0, 32'h1000_0008, 32'h0, 4'h0, 0, rd, 1'b0, 1'b0, lat, got_rd, got_e, ps, acc, ok);
            n_checks++; if (lat !== e_lat) $display("FAIL reset_fresh_lat: got %0d expected %0d", lat, e_lat); else n_pass++;
            n_checks++; if (got_rd !== e_rd) $display("FAIL reset_fresh_rdata: got %h expected %h", got_rd, e_rd); else n_pass++;
        end
    endtask

    task automatic test_zero_wait_write();
        int lat, acc;
        logic [31:0] got_rd;
        logic got_e, ok;
        logic [NS-1:0] ps;
        run_xfer(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0, lat, got_rd, got_e, ps, acc, ok);
        n_checks++; if (lat !== 3) $display("FAIL zw_latency: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (ps !== 6'b000100) $display("FAIL zw_psel: got %b expected 000100", ps); else n_pass++;
        n_checks++; if (got_e !== 1'b0) $display("FAIL zw_err: got %b expected 0", got_e); else n_pass++;
        n_checks++; if (acc !== 1) $display("FAIL zw_access_cycles: got %0d expected 1", acc); else n_pass++;
        n_checks++; if (ok !== 1'b1) $display("FAIL zw_bus_stable: got %b expected 1", ok); else n_pass++;
        n_checks++; if (got_rd !== model_rdata) $display("FAIL zw_rdata_held: got %h expected %h", got_rd, model_rdata); else n_pass++;
    endtask

    task automatic test_wait_read_err();
        int lat, acc;
        logic [31:0] got_rd;
        logic got_e, ok;
        logic [NS-1:0] ps;
        run_xfer(1'b0, 32'h1000_5000, 32'h1234_5678, 4'hF, 3, 32'h0000_00A5, 1'b1, 1'b1, lat, got_rd, got_e, ps, acc, ok);
        model_rdata = 32'h0000_00A5;
        n_checks++; if (lat !== 6) $display("FAIL wr_latency: got %0d expected 6", lat); else n_pass++;
        n_checks++; if (got_rd !== 32'hA5) $display("FAIL wr_rdata: got %h expected 000000a5", got_rd); else n_pass++;
        n_checks++; if (got_e !== 1'b1) $display("FAIL wr_err: got %b expected 1", got_e); else n_pass++;
        n_checks++; if (ps !== 6'b100000) $display("FAIL wr_psel: got %b expected 100000", ps); else n_pass++;
        n_checks++; if (ok !== 1'b1) $display("FAIL wr_bus_pstrb: got %b expected 1", ok); else n_pass++;
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs [3];
        logic        wrs   [3];
        addrs[0] = 32'h1000_6000; wrs[0] = 1'b0;
        addrs[1] = 32'h0FFF_FFFC; wrs[1] = 1'b0;
        addrs[2] = 32'h1000_7FF0; wrs[2] = 1'b1;
        model_rdata = rdata;
        for (int k = 0; k < 3; k++) begin
            int lat, acc, e_lat, e_acc;
            logic [31:0] got_rd, e_rd;
            logic got_e, ok, e_e;
            logic [NS-1:0] ps, e_ps;
            model(wrs[k], addrs[k], 0, 32'h0, 1'b0, e_lat, e_rd, e_e, e_ps, e_acc);
            run_xfer(wrs[k], addrs[k], $urandom, 4'hF, 0, 32'h0, 1'b0, 1'b1, lat, got_rd, got_e, ps, acc, ok);
            n_checks++; if (lat !== 2) $display("FAIL derr_latency[%0d]: got %0d expected 2", k, lat); else n_pass++;
            n_checks++; if (ps !== '0) $display("FAIL derr_psel[%0d]: got %b expected 0", k, ps); else n_pass++;
            n_checks++; if (got_e !== 1'b1) $display("FAIL derr_err[%0d]: got %b expected 1", k, got_e); else n_pass++;
            n_checks++; if (got_rd !== e_rd) $display("FAIL derr_rdata[%0d]: got %h expected %h", k, got_rd, e_rd); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int waits [2];
        waits[0] = -1;
        waits[1] = TMO - 1;
        for (int k = 0; k < 2; k++) begin
            int lat, acc, e_lat, e_acc;
            logic [31:0] got_rd, e_rd, rd;
            logic got_e, ok, e_e;
            logic [NS-1:0] ps, e_ps;
            rd = $urandom;
            model(1'b0, 32'h1000_1040, waits[k], rd, 1'b0, e_lat, e_rd, e_e, e_ps, e_acc);
            run_xfer(1'b0, 32'h1000_1040, 32'h0, 4'h0, waits[k], rd, 1'b0, 1'b0, lat, got_rd, got_e, ps, acc, ok);
            n_checks++; if (acc !== TMO) $display("FAIL tmo_access_cycles[%0d]: got %0d expected %0d", k, acc, TMO); else n_pass++;
            n_checks++; if (lat !== 2 + TMO) $display("FAIL tmo_latency[%0d]: got %0d expected %0d", k, lat, 2 + TMO); else n_pass++;
            n_checks++; if (got_e !== e_e) $display("FAIL tmo_err[%0d]: got %b expected %b", k, got_e, e_e); else n_pass++;
            n_checks++; if (got_rd !== e_rd) $display("FAIL tmo_rdata[%0d]: got %h expected %h", k, got_rd, e_rd); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int done   = 0;
        for (int n = 0; n < 12; n++) begin
            int lat, acc, e_lat, e_acc, w;
            logic [31:0] got_rd, e_rd, rd, a;
            logic got_e, ok, e_e, wr, se;
            logic [NS-1:0] ps, e_ps;
            a  = BASE + (32'($urandom_range(0, NS - 1)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 2);
            rd = $urandom;
            se = 1'($urandom_range(0, 1));
            model(wr, a, w, rd, se, e_lat, e_rd, e_e, e_ps, e_acc);
            exp_q.push_back(e_rd);
            issued++;
            run_xfer(wr, a, $urandom, 4'($urandom), w, rd, se, 1'b1, lat, got_rd, got_e, ps, acc, ok);
            if (lat > 0) done++;
            n_checks++; if (lat !== e_lat) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", n, lat, e_lat); else n_pass++;
            n_checks++; if (got_rd !== exp_q.pop_front()) $display("FAIL b2b_rdata[%0d]: got %h expected %h", n, got_rd, e_rd); else n_pass++;
            n_checks++; if (got_e !== e_e) $display("FAIL b2b_err[%0d]: got %b expected %b", n, got_e, e_e); else n_pass++;
        end
        @(negedge PCLK);
        n_checks++; if ({ready, busy} !== 2'b00) $display("FAIL b2b_ready_pulse: got %b expected 00", {ready, busy}); else n_pass++;
        n_checks++; if (done !== issued) $display("FAIL b2b_count: got %0d expected %0d", done, issued); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int lat, acc, e_lat, e_acc, w, kind;
            logic [31:0] got_rd, e_rd, rd, a;
            logic got_e, ok, e_e, wr, se;
            logic [NS-1:0] ps, e_ps;
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = BASE - (32'($urandom_range(1, 100)) << 2);
            else if (kind == 1) a = BASE + (32'($urandom_range(NS, NS + 1)) << 12) + 32'($urandom_range(0, 4095));
            else                a = BASE + (32'($urandom_range(0, NS - 1)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            wr = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(0, 6)) - 1;
            rd = $urandom;
            se = 1'($urandom_range(0, 1));
            model(wr, a, w, rd, se, e_lat, e_rd, e_e, e_ps, e_acc);
            run_xfer(wr, a, $urandom, 4'($urandom), w, rd, se, 1'($urandom_range(0, 1)), lat, got_rd, got_e, ps, acc, ok);
            n_checks++; if (lat !== e_lat) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, e_lat); else n_pass++;
            n_checks++; if (got_rd !== e_rd) $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, got_rd, e_rd); else n_pass++;
            n_checks++; if (got_e !== e_e) $display("FAIL rnd_err[%0d]: got %b expected %b", n, got_e, e_e); else n_pass++;
            n_checks++; if (ps !== e_ps) $display("FAIL rnd_psel[%0d]: got %b expected %b", n, ps, e_ps); else n_pass++;
            n_checks++; if (acc !== e_acc) $display("FAIL rnd_access[%0d]: got %0d expected %0d", n, acc, e_acc); else n_pass++;
            n_checks++; if (ok !== 1'b1) $display("FAIL rnd_bus[%0d]: got %b expected 1", n, ok); else n_pass++;
        end
    endtask

    task automatic test_param_sweep();
        logic [15:0] rd;
        d2_transfer = 1'b1; d2_write = 1'b1; d2_addr = 32'h1000_0100; d2_wdata = 16'h1234; d2_strb = 2'b11;
        @(negedge PCLK);
        d2_transfer = 1'b0;
        n_checks++; if ({d2_psel, d2_penable} !== 3'b100) $display("FAIL p2_setup: got %b expected 100", {d2_psel, d2_penable}); else n_pass++;
        @(negedge PCLK);
        n_checks++; if ({d2_psel, d2_penable, d2_pwdata} !== {3'b101, 16'h1234})
            $display("FAIL p2_access: got %h expected %h", {d2_psel, d2_penable, d2_pwdata}, {3'b101, 16'h1234}); else n_pass++;
        d2_pready = 2'b10; d2_pslverr = 2'b01;
        @(negedge PCLK);
        d2_pready = 2'b00; d2_pslverr = 2'b00;
        n_checks++; if ({d2_ready, d2_err, d2_busy} !== 3'b100) $display("FAIL p2_wr_done: got %b expected 100", {d2_ready, d2_err, d2_busy}); else n_pass++;
        rd = 16'($urandom);
        d2_transfer = 1'b1; d2_write = 1'b0; d2_addr = 32'h1000_0004;
        @(negedge PCLK);
        d2_transfer = 1'b0;
        n_checks++; if (d2_psel !== 2'b01) $display("FAIL p2_rd_psel: got %b expected 01", d2_psel); else n_pass++;
        @(negedge PCLK);
        d2_pready = 2'b01; d2_prdata = {16'($urandom), rd};
        @(negedge PCLK);
        d2_pready = 2'b00;
        n_checks++; if ({d2_ready, d2_rdata} !== {1'b1, rd}) $display("FAIL p2_rd_data: got %h expected %h", {d2_ready, d2_rdata}, {1'b1, rd}); else n_pass++;
        d2_transfer = 1'b1; d2_write = 1'b0; d2_addr = 32'h1000_0200;
        @(negedge PCLK);
        d2_transfer = 1'b0;
        n_checks++; if ({d2_psel, d2_busy} !== 3'b001) $display("FAIL p2_derr_psel: got %b expected 001", {d2_psel, d2_busy}); else n_pass++;
        @(negedge PCLK);
        n_checks++; if ({d2_ready, d2_err, d2_rdata} !== {2'b11, 16'h0})
            $display("FAIL p2_derr_done: got %h expected %h", {d2_ready, d2_err, d2_rdata}, {2'b11, 16'h0}); else n_pass++;
    endtask

    initial begin
        PRESET = 1'b1;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        d2_transfer = 1'b0; d2_write = 1'b0; d2_addr = '0; d2_wdata = '0; d2_strb = '0;
        d2_prdata = '0; d2_pready = '0; d2_pslverr = '0;
        test_reset();
        test_zero_wait_write();
        test_wait_read_err();
        test_decode_err();
        test_timeout();
        test_back_to_back();
        test_random();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
